// File: rtl/rvlab_clk_reconf.sv
// TL-UL to MMCM DRP bridge with CTRL (mmcm_rst) / STATUS (locked) registers; CLK_RECONF_TIMEOUT_EN adds DRP timeout.
// Latency: local registers respond 1 cycle after accept; DRP responds 1 cycle after drdy (or timeout).
// Backpressure: one request outstanding; a_ready low from accept until the cycle after the d_ready handshake.
package tlul_pkg;
   localparam logic [2:0] PutFullData    = 3'h0;
   localparam logic [2:0] PutPartialData = 3'h1;
   localparam logic [2:0] Get            = 3'h4;
   localparam logic [2:0] AccessAck      = 3'h0;
   localparam logic [2:0] AccessAckData  = 3'h1;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;
endpackage

module rvlab_clk_reconf #(
   parameter int TimeoutCycles  = 64,
   parameter int LockSyncStages = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  tlul_pkg::tl_h2d_t   tl_i,
   output tlul_pkg::tl_d2h_t   tl_o,
   output logic [6:0]          drp_daddr_o,
   output logic [15:0]         drp_di_o,
   input  logic [15:0]         drp_do_i,
   output logic                drp_den_o,
   output logic                drp_dwe_o,
   input  logic                drp_drdy_i,
   output logic                mmcm_rst_o,
   input  logic                mmcm_locked_i
);
   import tlul_pkg::*;

   typedef enum logic [1:0] {IDLE, DRP_WAIT, RESP} state_e;

   state_e                    state;
   logic                      a_ready_q, d_valid_q, d_error_q, ctrl_q;
   logic [2:0]                d_opcode_q;
   logic [1:0]                d_size_q;
   logic [7:0]                d_source_q;
   logic [31:0]               d_data_q;
   logic [LockSyncStages-1:0] lock_sync_q;

   logic [9:0]  off;
   logic        is_get, is_put, in_drp, req_err, timeout;
   logic [31:0] local_rdata;
   logic        unused_tl;

   assign off    = tl_i.a_address[9:0];
   assign is_get = (tl_i.a_opcode == Get);
   assign is_put = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
   assign in_drp = ~off[9];
   // DRP registers are 16 bits wide, so a partial write of the low half is meaningless.
   assign req_err = ~(is_get | is_put) || (tl_i.a_size == 2'd3) || (off >= 10'h208) ||
                    (in_drp && is_put && (tl_i.a_mask[1:0] != 2'b11));
   assign local_rdata = off[2] ? {31'h0, lock_sync_q[LockSyncStages-1]} : {31'h0, ctrl_q};
   assign unused_tl   = ^{tl_i.a_param, tl_i.a_address[31:10], off[1:0], tl_i.a_mask[3:2],
                          tl_i.a_data[31:16]};

   always_ff @(posedge clk_i) begin
      if (!rst_ni) lock_sync_q <= '0;
      else         lock_sync_q <= {lock_sync_q[LockSyncStages-2:0], mmcm_locked_i};
   end

`ifdef CLK_RECONF_TIMEOUT_EN
   localparam int CntW = $clog2(TimeoutCycles + 1);
   logic [CntW-1:0] cnt_q;

   // Counter sits at zero outside DRP_WAIT, so it reads 0 in the strobe cycle.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || state != DRP_WAIT) cnt_q <= '0;
      else                              cnt_q <= cnt_q + 1'b1;
   end
   assign timeout = ((cnt_q + 1'b1) == CntW'(TimeoutCycles));
`else
   localparam int unused_timeout_cycles = TimeoutCycles;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state       <= IDLE;
         a_ready_q   <= 1'b1;
         d_valid_q   <= 1'b0;
         d_error_q   <= 1'b0;
         d_opcode_q  <= AccessAck;
         d_size_q    <= '0;
         d_source_q  <= '0;
         d_data_q    <= '0;
         drp_den_o   <= 1'b0;
         drp_dwe_o   <= 1'b0;
         drp_daddr_o <= '0;
         drp_di_o    <= '0;
         ctrl_q      <= 1'b0;
      end else begin
         drp_den_o <= 1'b0;
         drp_dwe_o <= 1'b0;
         unique case (state)
            IDLE: if (tl_i.a_valid) begin
               a_ready_q  <= 1'b0;
               d_opcode_q <= is_get ? AccessAckData : AccessAck;
               d_size_q   <= tl_i.a_size;
               d_source_q <= tl_i.a_source;
               d_error_q  <= req_err;
               d_data_q   <= '0;
               if (req_err) begin
                  state     <= RESP;
                  d_valid_q <= 1'b1;
               end else if (in_drp) begin
                  state       <= DRP_WAIT;
                  drp_den_o   <= 1'b1;
                  drp_dwe_o   <= is_put;
                  drp_daddr_o <= off[8:2];
                  drp_di_o    <= tl_i.a_data[15:0];
               end else begin
                  state     <= RESP;
                  d_valid_q <= 1'b1;
                  if (is_put) begin
                     if (!off[2] && tl_i.a_mask[0]) ctrl_q <= tl_i.a_data[0];
                  end else begin
                     d_data_q <= local_rdata;
                  end
               end
            end
            DRP_WAIT: if (drp_drdy_i) begin
               d_data_q  <= {16'h0, drp_do_i};
               state     <= RESP;
               d_valid_q <= 1'b1;
            end else if (timeout) begin
               d_error_q <= 1'b1;
               state     <= RESP;
               d_valid_q <= 1'b1;
            end
            RESP: if (tl_i.d_ready) begin
               d_valid_q <= 1'b0;
               a_ready_q <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mmcm_rst_o = ctrl_q;

   always_comb begin
      tl_o          = '0;
      tl_o.d_valid  = d_valid_q;
      tl_o.d_opcode = d_opcode_q;
      tl_o.d_size   = d_size_q;
      tl_o.d_source = d_source_q;
      tl_o.d_data   = d_data_q;
      tl_o.d_error  = d_error_q;
      tl_o.a_ready  = a_ready_q;
   end
endmodule

// File: tb/tb_rvlab_clk_reconf.sv
// Directed bench for rvlab_clk_reconf: spec-level transaction model, DRP slave model, per-cycle compare process.
module tb_rvlab_clk_reconf;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   tlul_pkg::tl_h2d_t tl_i;
   tlul_pkg::tl_d2h_t tl_o;
   logic [6:0]  drp_daddr;
   logic [15:0] drp_di, drp_do;
   logic drp_den, drp_dwe, drp_drdy, mmcm_rst, mmcm_locked;

   rvlab_clk_reconf #(.TimeoutCycles(64), .LockSyncStages(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .tl_i(tl_i), .tl_o(tl_o),
      .drp_daddr_o(drp_daddr), .drp_di_o(drp_di), .drp_do_i(drp_do),
      .drp_den_o(drp_den), .drp_dwe_o(drp_dwe), .drp_drdy_i(drp_drdy),
      .mmcm_rst_o(mmcm_rst), .mmcm_locked_i(mmcm_locked));

   always #5 clk = ~clk;

   int vec = 0, errs = 0;
   // expected response / strobe of the transaction in flight
   logic        exp_active = 1'b0, mon_en = 1'b0;
   logic [2:0]  e_opc;
   logic [31:0] e_data;
   logic        e_err, e_den, e_dwe;
   logic [6:0]  e_daddr;
   logic [15:0] e_di;
   logic [7:0]  e_src = 8'h0;
   logic [1:0]  e_size;
   logic        ctrl_m = 1'b0, lock_m = 1'b0;
   int          den_cnt = 0;
   // DRP slave model
   logic [15:0] drp_mem [128];
   int          resp_delay = -1, cd = 0;
   logic        inject = 1'b0;
   logic [6:0]  r_addr = '0;
   logic [31:0] got_d;
   logic        got_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      drp_drdy = 1'b0;
      drp_do   = 16'h0;
      for (int i = 0; i < 128; i++) drp_mem[i] = 16'h0;
      drp_mem[8] = 16'h1234;
      drp_mem[1] = 16'h00C3;
      forever begin
         @(negedge clk);
         drp_drdy = 1'b0;
         if (inject) begin
            drp_drdy = 1'b1;
            drp_do   = 16'hDEAD;
            inject   = 1'b0;
         end
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               drp_drdy = 1'b1;
               drp_do   = drp_mem[r_addr];
            end
         end
         if (drp_den) begin
            r_addr = drp_daddr;
            if (drp_dwe) drp_mem[drp_daddr] = drp_di;
            if (resp_delay > 0) cd = resp_delay;
         end
      end
   end

   // compare process
   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         check("mmcm_rst", {31'h0, mmcm_rst}, {31'h0, ctrl_m});
         if (exp_active) begin
            check("a_ready_busy", {31'h0, tl_o.a_ready}, 32'h0);
            if (tl_o.d_valid) begin
               check("d_opcode", {29'h0, tl_o.d_opcode}, {29'h0, e_opc});
               check("d_data", tl_o.d_data, e_data);
               check("d_error", {31'h0, tl_o.d_error}, {31'h0, e_err});
               check("d_source", {24'h0, tl_o.d_source}, {24'h0, e_src});
               check("d_size", {30'h0, tl_o.d_size}, {30'h0, e_size});
               check("d_param_sink", {28'h0, tl_o.d_param, tl_o.d_sink}, 32'h0);
            end
            if (drp_den) begin
               den_cnt++;
               check("daddr", {25'h0, drp_daddr}, {25'h0, e_daddr});
               check("di", {16'h0, drp_di}, {16'h0, e_di});
               check("dwe", {31'h0, drp_dwe}, {31'h0, e_dwe});
            end
         end else begin
            check("idle_a_ready", {31'h0, tl_o.a_ready}, 32'h1);
            check("idle_d_valid", {31'h0, tl_o.d_valid}, 32'h0);
            check("idle_den", {31'h0, drp_den}, 32'h0);
         end
      end
   end

   task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input logic [1:0] size, input int delay,
                         input int hold, input int exp_lat,
                         output logic [31:0] rd, output logic re);
      logic [9:0] off;
      logic is_put, bad, late, ctrl_next;
      int n;
      off    = addr[9:0];
      is_put = (op == 3'd0) || (op == 3'd1);
      bad    = !(is_put || op == 3'd4) || size > 2'd2 || off >= 10'h208 ||
               (off < 10'h200 && is_put && mask[1:0] != 2'b11);
`ifdef CLK_RECONF_TIMEOUT_EN
      late = (delay < 0) || (delay > 63);
`else
      late = (delay < 0);
`endif
      e_opc = (op == 3'd4) ? 3'd1 : 3'd0;
      e_err = bad; e_data = 32'h0; e_den = 1'b0;
      e_daddr = off[8:2]; e_dwe = is_put; e_di = data[15:0];
      ctrl_next = ctrl_m;
      if (!bad) begin
         if (off < 10'h200) begin
            e_den = 1'b1;
            if (late) e_err = 1'b1;
            else e_data = {16'h0, is_put ? data[15:0] : drp_mem[off[8:2]]};
         end else if (off < 10'h204) begin
            if (is_put) begin
               if (mask[0]) ctrl_next = data[0];
            end else e_data = {31'h0, ctrl_m};
         end else if (!is_put) e_data = {31'h0, lock_m};
      end
      e_src = e_src + 8'd1; e_size = size;
      resp_delay = delay; den_cnt = 0;
      tl_i.a_valid = 1'b1; tl_i.a_opcode = op; tl_i.a_address = addr; tl_i.a_data = data;
      tl_i.a_mask = mask; tl_i.a_size = size; tl_i.a_source = e_src;
      @(posedge clk); #1;
      tl_i.a_valid = 1'b0;
      ctrl_m = ctrl_next;
      exp_active = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tl_o.d_valid && n < 300);
      check("latency", n, exp_lat);
      rd = tl_o.d_data;
      re = tl_o.d_error;
      repeat (hold) @(negedge clk);
      tl_i.d_ready = 1'b1;
      @(posedge clk); #1;
      tl_i.d_ready = 1'b0;
      exp_active = 1'b0;
      check("den_count", den_cnt, {31'h0, e_den});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tl_i = '0;
      mmcm_locked = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_a_ready", {31'h0, tl_o.a_ready}, 32'h1);
      check("rst_d_valid", {31'h0, tl_o.d_valid}, 32'h0);
      check("rst_drp", {drp_den, drp_dwe, drp_daddr, drp_di}, 32'h0);
      check("rst_mmcm_rst", {31'h0, mmcm_rst}, 32'h0);
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // DRP read / write
      do_req(3'd4, 32'h020, 32'h0, 4'hF, 2'd2, 3, 0, 5, got_d, got_e);
      check("rd_lit", got_d, 32'h0000_1234);
      do_req(3'd0, 32'h050, 32'hABCD_5A5A, 4'hF, 2'd2, 2, 0, 4, got_d, got_e);
      check("wr_err_lit", {31'h0, got_e}, 32'h0);
      do_req(3'd4, 32'h050, 32'h0, 4'hF, 2'd2, 1, 0, 3, got_d, got_e);
      check("rdback_lit", got_d, 32'h0000_5A5A);
      do_req(3'd1, 32'h024, 32'h0000_0077, 4'h3, 2'd1, 1, 0, 3, got_d, got_e);

`ifdef CLK_RECONF_TIMEOUT_EN
      do_req(3'd4, 32'h004, 32'h0, 4'hF, 2'd2, -1, 0, 65, got_d, got_e);
      check("to_err_lit", {31'h0, got_e}, 32'h1);
      check("to_data_lit", got_d, 32'h0);
      inject = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      do_req(3'd4, 32'h004, 32'h0, 4'hF, 2'd2, 2, 0, 4, got_d, got_e);
      check("after_to_lit", got_d, 32'h0000_00C3);
      do_req(3'd4, 32'h004, 32'h0, 4'hF, 2'd2, 63, 0, 65, got_d, got_e);
      check("drdy_wins_lit", {31'h0, got_e}, 32'h0);
      do_req(3'd4, 32'h004, 32'h0, 4'hF, 2'd2, 64, 3, 65, got_d, got_e);
      check("drdy_late_lit", {31'h0, got_e}, 32'h1);
`endif

      // CTRL / STATUS and lock synchroniser depth
      do_req(3'd0, 32'h200, 32'h1, 4'hF, 2'd2, 0, 0, 1, got_d, got_e);
      check("mmcm_rst_lit", {31'h0, mmcm_rst}, 32'h1);
      do_req(3'd4, 32'h200, 32'h0, 4'hF, 2'd2, 0, 0, 1, got_d, got_e);
      mmcm_locked = 1'b1; lock_m = 1'b0;
      do_req(3'd4, 32'h204, 32'h0, 4'hF, 2'd2, 0, 0, 1, got_d, got_e);
      check("lock_0cyc_lit", got_d, 32'h0);
      mmcm_locked = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      mmcm_locked = 1'b1;
      @(posedge clk); #1;
      do_req(3'd4, 32'h204, 32'h0, 4'hF, 2'd2, 0, 0, 1, got_d, got_e);
      check("lock_1cyc_lit", got_d, 32'h0);
      mmcm_locked = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      mmcm_locked = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      lock_m = 1'b1;
      do_req(3'd4, 32'h204, 32'h0, 4'hF, 2'd2, 0, 0, 1, got_d, got_e);
      check("lock_2cyc_lit", got_d, 32'h1);
      do_req(3'd0, 32'h204, 32'h0, 4'hF, 2'd2, 0, 0, 1, got_d, got_e);
      check("status_put_lit", {31'h0, got_e}, 32'h0);

      // error responses
      do_req(3'd4, 32'h300, 32'h0, 4'hF, 2'd2, 1, 0, 1, got_d, got_e);
      check("err_addr_lit", {31'h0, got_e}, 32'h1);
      do_req(3'd1, 32'h010, 32'h0, 4'h4, 2'd2, 1, 0, 1, got_d, got_e);
      check("err_mask_lit", {31'h0, got_e}, 32'h1);
      do_req(3'd0, 32'h200, 32'h0, 4'hF, 2'd3, 0, 0, 1, got_d, got_e);
      check("ctrl_kept_lit", {31'h0, mmcm_rst}, 32'h1);
      do_req(3'd2, 32'h020, 32'h0, 4'hF, 2'd2, 1, 0, 1, got_d, got_e);

      // backpressure
      do_req(3'd4, 32'h200, 32'h0, 4'hF, 2'd2, 0, 10, 1, got_d, got_e);

      // reset while waiting for drdy
      resp_delay = -1; den_cnt = 0;
      e_src = e_src + 8'd1; e_size = 2'd2; e_opc = 3'd1; e_err = 1'b0; e_data = 32'h0;
      e_den = 1'b1; e_daddr = 7'd2; e_dwe = 1'b0; e_di = 16'h0;
      tl_i.a_valid = 1'b1; tl_i.a_opcode = 3'd4; tl_i.a_address = 32'h008; tl_i.a_data = 32'h0;
      tl_i.a_mask = 4'hF; tl_i.a_size = 2'd2; tl_i.a_source = e_src;
      @(posedge clk); #1;
      tl_i.a_valid = 1'b0;
      exp_active = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      exp_active = 1'b0;
      ctrl_m = 1'b0;
      check("rst_mid_d_valid", {31'h0, tl_o.d_valid}, 32'h0);
      check("rst_mid_a_ready", {31'h0, tl_o.a_ready}, 32'h1);
      check("rst_mid_mmcm_rst", {31'h0, mmcm_rst}, 32'h0);
      check("rst_mid_den_cnt", den_cnt, 32'h1);
      rst_n = 1'b1;
      inject = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("late_drdy_ignored", {31'h0, tl_o.d_valid}, 32'h0);
      do_req(3'd4, 32'h020, 32'h0, 4'hF, 2'd2, 1, 0, 3, got_d, got_e);
      check("recover_lit", got_d, 32'h0000_1234);

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule

// File: doc/rvlab_clk_reconf.md
Name: rvlab_clk_reconf

Overview:
TL-UL device on the peripheral crossbar's `clk_reconf` port, i.e. the consumer of `tl_clk_reconf_o` leaving the core. It translates TL-UL Get/Put accesses into Xilinx MMCM DRP read/write transactions. It also provides a control register for MMCM reset and a status register reporting MMCM lock. Firmware uses it to retune FPGA clocks at run time.

Parameters:
TimeoutCycles, 64, cycles to wait for `drp_drdy_i` after a DRP strobe before an error response; counter width is $clog2(TimeoutCycles+1)
LockSyncStages, 2, flip-flop stages synchronising `mmcm_locked_i`; minimum 2

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset, synchronous, active-low
tl_i  in  tlul_pkg::tl_h2d_t  TL-UL request from xbar_peri
tl_o  out  tlul_pkg::tl_d2h_t  TL-UL response to xbar_peri
drp_daddr_o  out  7  DRP address
drp_di_o  out  16  DRP write data
drp_do_i  in  16  DRP read data
drp_den_o  out  1  DRP enable strobe, 1-cycle pulse
drp_dwe_o  out  1  DRP write enable, valid with `drp_den_o`
drp_drdy_i  in  1  DRP ready, 1-cycle pulse
mmcm_rst_o  out  1  MMCM reset, level
mmcm_locked_i  in  1  MMCM locked, asynchronous

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous, active-low: `rst_ni` is sampled on the rising edge of `clk_i`.
- Reset values:
  - state=IDLE.
  - `tl_o.a_ready`=1, `tl_o.d_valid`=0.
  - `drp_den_o`=0, `drp_dwe_o`=0, `drp_daddr_o`=0, `drp_di_o`=0.
  - `mmcm_rst_o`=0; sync chain=0.
- Address map (byte offset a_address[9:0]; upper bits ignored):
  - 0x000-0x1FC: DRP window, daddr = a_address[8:2].
  - 0x200 CTRL: bit0 = mmcm_rst, RW; other bits read 0.
  - 0x204 STATUS: bit0 = synchronised locked, RO; writes ignored, no error.
  - 0x208 and above: error response, no side effect.
- States: IDLE, DRP_WAIT, RESP.
- IDLE:
  - `a_ready`=1.
  - On `a_valid` with a DRP-window address:
    - Drive `drp_den_o`=1 for exactly the next cycle, with `daddr` and `di` = a_data[15:0].
    - `drp_dwe_o`=1 for PutFullData/PutPartialData.
    - Go to DRP_WAIT; clear the timeout counter.
  - On `a_valid` with a local register or error address: update CTRL if it is a Put and go to RESP. Response is visible 1 cycle after acceptance.
- DRP_WAIT:
  - `a_ready`=0.
  - On `drp_drdy_i`: capture `drp_do_i` into d_data[15:0] (upper bits 0), go to RESP.
  - Counter increments each cycle. At TimeoutCycles without `drdy`, go to RESP with d_error=1 and d_data=0.
  - If `drdy` coincides with the timeout cycle, `drdy` wins: no error.
- RESP:
  - `d_valid`=1; `a_ready`=0.
  - Fields held stable until `d_ready`; on `d_ready` go to IDLE.
  - d_opcode = AccessAckData for Get, AccessAck for Put.
  - d_source and d_size echo the accepted request; d_param=0; d_sink=0.
- Error conditions: respond with d_error=1 and no DRP strobe / CTRL update for:
  - a DRP Put with a_mask[1:0] != 2'b11;
  - an opcode other than Get, PutFullData or PutPartialData;
  - a_size > 2.
- Late `drp_drdy_i` arriving in IDLE or RESP is ignored.
- Only one request is outstanding; `a_ready` is low from acceptance until the cycle after the `d_ready` handshake.
- `mmcm_rst_o` is driven directly by CTRL.bit0, registered. It changes in the cycle after acceptance of the CTRL Put.
- Reset mid-operation: on the next edge, return to IDLE, drop `d_valid` and `den`, clear CTRL. A pending `drdy` is later ignored.

Optional Feature:
CLK_RECONF_TIMEOUT_EN:
- Defined: timeout counter and timeout error response exist as above.
- Undefined: DRP_WAIT waits indefinitely for `drp_drdy_i`; no counter logic; `TimeoutCycles` is unused.

Test Plan:
- DRP read: Get 0x020, model returns `drdy` with do=0x1234 three cycles after `den` -> one `den` pulse, daddr=0x08, dwe=0; AccessAckData with d_data=0x0000_1234, d_error=0.
- DRP write: PutFullData 0x050, data 0xABCD_5A5A, mask 0xF -> `den`=`dwe`=1 for one cycle, daddr=0x14, di=0x5A5A; AccessAck, d_error=0.
- Timeout (macro defined, TimeoutCycles=64): Get 0x004 with no `drdy` -> d_error=1, d_data=0, 64 cycles after `den`. A later `drdy` then a second Get -> correct, independent response.
- CTRL/STATUS: Put 0x200 data 1 -> `mmcm_rst_o`=1 next cycle. Raise `mmcm_locked_i` -> Get 0x204 returns 1 only after 2 cycles. Put 0x204 -> AccessAck, no error.
- Errors: Get 0x300, Put 0x010 with mask 0x4 -> d_error=1, no `den` pulse, CTRL unchanged.
- Backpressure/reset: hold `d_ready`=0 for 10 cycles -> `d_valid` and fields stable, `a_ready`=0. Assert `rst_ni`=0 in DRP_WAIT -> next cycle `d_valid`=0, `a_ready`=1, `mmcm_rst_o`=0.
